// File: rtl/dff_bank_sequencer.sv
// -----------------------------------------------------------------------------
// dff_bank_sequencer
//
// Shares one WIDTH-bit bank of preset/clear D flip-flops among NREQ requesters.
// Each requester may LOAD data, SET all bits, CLEAR all bits or READ the bank.
// Requests are granted round-robin. The block drives the bank's d/load/pre/clr
// lines with timed pulses, then samples the bank output and returns it to the
// granted requester with a one-cycle ack.
//
// Optional build macro: DFF_SEQ_CHECK_EN
//   When defined, adds output 'err'. It pulses together with ack when the
//   sampled readback differs from the value the operation should have left in
//   the bank (SET -> all ones, CLEAR -> all zeros, LOAD -> latched wdata).
//   READ never flags. When undefined there is no err port and no compare logic.
//
// Ports
//   clk      in   1           clock, rising edge
//   clr_n    in   1           asynchronous active-low reset
//   req      in   NREQ        request per requester, held until ack
//   op       in   2*NREQ      op[2i+1:2i]: 00 LOAD, 01 SET, 10 CLEAR, 11 READ
//   wdata    in   WIDTH*NREQ  LOAD data, wdata[WIDTH*i +: WIDTH] for requester i
//   ff_q     in   WIDTH       bank readback
//   ff_d     out  WIDTH       bank data input (holds outside LOAD)
//   ff_load  out  1           bank capture strobe, one cycle
//   ff_pre   out  1           bank preset, all bits
//   ff_clr   out  1           bank clear, all bits
//   gnt      out  NREQ        one-hot grant, high from grant until ack
//   ack      out  NREQ        one-cycle completion pulse
//   rdata    out  WIDTH       ff_q sampled at completion, held afterwards
//   busy     out  1           high whenever the sequencer is not idle
//   err      out  1           (DFF_SEQ_CHECK_EN only) readback mismatch flag
// -----------------------------------------------------------------------------
`default_nettype none

module dff_bank_sequencer #(
    parameter int NREQ      = 4,
    parameter int WIDTH     = 8,
    parameter int PULSE_CYC = 2,
    parameter int RECOV_CYC = 1
) (
    input  logic                    clk,
    input  logic                    clr_n,
    input  logic [NREQ-1:0]         req,
    input  logic [2*NREQ-1:0]       op,
    input  logic [WIDTH*NREQ-1:0]   wdata,
    input  logic [WIDTH-1:0]        ff_q,
    output logic [WIDTH-1:0]        ff_d,
    output logic                    ff_load,
    output logic                    ff_pre,
    output logic                    ff_clr,
    output logic [NREQ-1:0]         gnt,
    output logic [NREQ-1:0]         ack,
    output logic [WIDTH-1:0]        rdata,
    output logic                    busy
`ifdef DFF_SEQ_CHECK_EN
    ,
    output logic                    err
`endif
);

    localparam int IW   = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int MAXC = (PULSE_CYC > RECOV_CYC) ? PULSE_CYC : RECOV_CYC;
    localparam int CW   = (MAXC > 0) ? $clog2(MAXC + 1) : 1;

    localparam logic [CW-1:0] PULSE_LAST = CW'(PULSE_CYC - 1);
    localparam logic [CW-1:0] RECOV_LAST = CW'(RECOV_CYC - 1);

    localparam logic [1:0] OP_LOAD  = 2'b00;
    localparam logic [1:0] OP_SET   = 2'b01;
    localparam logic [1:0] OP_CLEAR = 2'b10;
    localparam logic [1:0] OP_READ  = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_PULSE  = 3'd2,
        ST_RECOV  = 3'd3,
        ST_SAMPLE = 3'd4
    } state_t;

    // Round-robin pick: scanning from the highest offset down lets the
    // lowest offset from ptr overwrite last, so it wins. MSB = any request.
    function automatic logic [IW:0] pick_winner(input logic [NREQ-1:0] req_v,
                                                input logic [IW-1:0]   ptr);
        logic [IW-1:0] win;
        int            idx;
        win = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = (int'(ptr) + k) % NREQ;
            win = req_v[IW'(idx)] ? IW'(idx) : win;
        end
        return {|req_v, win};
    endfunction

    // Value the bank should hold after a completed SET/CLEAR/LOAD.
    function automatic logic [WIDTH-1:0] expected_value(input logic [1:0]       op_v,
                                                        input logic [WIDTH-1:0] data_v);
        logic [WIDTH-1:0] val;
        case (op_v)
            OP_SET:   val = {WIDTH{1'b1}};
            OP_CLEAR: val = {WIDTH{1'b0}};
            OP_LOAD:  val = data_v;
            default:  val = {WIDTH{1'b0}};
        endcase
        return val;
    endfunction

    state_t              state_r;
    state_t              state_nx_s;
    logic [CW-1:0]       cnt_r;
    logic [CW-1:0]       cnt_nx_s;
    logic [IW-1:0]       rr_ptr_r;
    logic [IW-1:0]       rr_ptr_nx_s;
    logic [1:0]          op_r;
    logic [1:0]          op_nx_s;
    logic [WIDTH-1:0]    data_r;
    logic [WIDTH-1:0]    data_nx_s;
    logic [NREQ-1:0]     gnt_nx_s;

    logic [IW:0]         pick_s;
    logic                any_req_s;
    logic [IW-1:0]       win_idx_s;
    logic [1:0]          win_op_s;
    logic [WIDTH-1:0]    win_data_s;
    logic [NREQ-1:0]     win_onehot_s;
    logic                grant_s;

    logic [WIDTH-1:0]    ff_d_r;
    logic                ff_load_r;
    logic                ff_pre_r;
    logic                ff_clr_r;
    logic [NREQ-1:0]     gnt_r;
    logic [NREQ-1:0]     ack_r;
    logic [WIDTH-1:0]    rdata_r;
    logic                busy_r;

    // Arbitration: select the winning requester and its op/data.
    always_comb begin
        pick_s       = pick_winner(req, rr_ptr_r);
        any_req_s    = pick_s[IW];
        win_idx_s    = pick_s[IW-1:0];
        win_op_s     = 2'(op >> (2 * int'(win_idx_s)));
        win_data_s   = WIDTH'(wdata >> (WIDTH * int'(win_idx_s)));
        win_onehot_s = {{(NREQ-1){1'b0}}, 1'b1} << win_idx_s;
        grant_s      = (state_r == ST_IDLE) && any_req_s;
    end

    // Next values of the latched transaction (op, data, grant, pointer).
    always_comb begin
        op_nx_s     = op_r;
        data_nx_s   = data_r;
        gnt_nx_s    = gnt_r;
        rr_ptr_nx_s = rr_ptr_r;
        if (grant_s) begin
            op_nx_s     = win_op_s;
            data_nx_s   = win_data_s;
            gnt_nx_s    = win_onehot_s;
            rr_ptr_nx_s = (int'(win_idx_s) == NREQ - 1) ? '0 : (win_idx_s + IW'(1));
        end else begin
            rr_ptr_nx_s = rr_ptr_r;
        end
    end

    // FSM next-state and duration counter.
    always_comb begin
        state_nx_s = state_r;
        cnt_nx_s   = cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (any_req_s) begin
                    case (win_op_s)
                        OP_LOAD:  state_nx_s = ST_LOAD;
                        OP_SET:   state_nx_s = ST_PULSE;
                        OP_CLEAR: state_nx_s = ST_PULSE;
                        OP_READ:  state_nx_s = ST_SAMPLE;
                        default:  state_nx_s = ST_IDLE;
                    endcase
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_LOAD:   state_nx_s = ST_SAMPLE;
            ST_PULSE: begin
                if (cnt_r == PULSE_LAST) begin
                    state_nx_s = ST_RECOV;
                end else begin
                    state_nx_s = ST_PULSE;
                end
            end
            ST_RECOV: begin
                if (cnt_r == RECOV_LAST) begin
                    state_nx_s = ST_SAMPLE;
                end else begin
                    state_nx_s = ST_RECOV;
                end
            end
            ST_SAMPLE: state_nx_s = ST_IDLE;
            default:   state_nx_s = ST_IDLE;
        endcase

        // Counter restarts on every state entry; only timed states advance it.
        if (state_nx_s != state_r) begin
            cnt_nx_s = '0;
        end else if ((state_r == ST_PULSE) || (state_r == ST_RECOV)) begin
            cnt_nx_s = cnt_r + CW'(1);
        end else begin
            cnt_nx_s = cnt_r;
        end
    end

    // FSM state, counter, pointer and latched transaction registers.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_r  <= ST_IDLE;
            cnt_r    <= '0;
            rr_ptr_r <= '0;
            op_r     <= 2'b00;
            data_r   <= '0;
        end else begin
            state_r  <= state_nx_s;
            cnt_r    <= cnt_nx_s;
            rr_ptr_r <= rr_ptr_nx_s;
            op_r     <= op_nx_s;
            data_r   <= data_nx_s;
        end
    end

    // Bank drive outputs, decoded from the next state so they are registered.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            ff_d_r    <= '0;
            ff_load_r <= 1'b0;
            ff_pre_r  <= 1'b0;
            ff_clr_r  <= 1'b0;
        end else begin
            ff_load_r <= (state_nx_s == ST_LOAD);
            ff_pre_r  <= (state_nx_s == ST_PULSE) && (op_nx_s == OP_SET);
            ff_clr_r  <= (state_nx_s == ST_PULSE) && (op_nx_s == OP_CLEAR);
            ff_d_r    <= (state_nx_s == ST_LOAD) ? data_nx_s : ff_d_r;
        end
    end

    // Requester handshake outputs: grant, completion ack, readback, busy.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            gnt_r   <= '0;
            ack_r   <= '0;
            rdata_r <= '0;
            busy_r  <= 1'b0;
        end else begin
            gnt_r   <= (state_nx_s != ST_IDLE) ? gnt_nx_s : '0;
            ack_r   <= (state_r == ST_SAMPLE) ? gnt_r : '0;
            rdata_r <= (state_r == ST_SAMPLE) ? ff_q : rdata_r;
            busy_r  <= (state_nx_s != ST_IDLE);
        end
    end

`ifdef DFF_SEQ_CHECK_EN
    logic err_r;

    // Readback compare, flagged in the same cycle as ack.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            err_r <= 1'b0;
        end else begin
            err_r <= (state_r == ST_SAMPLE) && (op_r != OP_READ) &&
                     (ff_q != expected_value(op_r, data_r));
        end
    end

    assign err = err_r;
`endif

    assign ff_d    = ff_d_r;
    assign ff_load = ff_load_r;
    assign ff_pre  = ff_pre_r;
    assign ff_clr  = ff_clr_r;
    assign gnt     = gnt_r;
    assign ack     = ack_r;
    assign rdata   = rdata_r;
    assign busy    = busy_r;

endmodule

`default_nettype wire

// File: tb/tb_dff_bank_sequencer.sv
// -----------------------------------------------------------------------------
// tb_dff_bank_sequencer
//
// Directed bench for dff_bank_sequencer (NREQ=4, WIDTH=8, PULSE_CYC=2,
// RECOV_CYC=1). Models the flip-flop bank (async preset/clear, load on edge),
// applies a table of single transactions with hand-computed grant, latency,
// pulse counts and readback, and adds hand-written sequences for reset during
// a SET, round-robin rotation, request drop after grant and the optional
// readback checker (DFF_SEQ_CHECK_EN).
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_dff_bank_sequencer;

    logic        clk;
    logic        clr_n;
    logic [3:0]  req;
    logic [7:0]  op;
    logic [31:0] wdata;
    logic [7:0]  ff_q;
    logic [7:0]  ff_d;
    logic        ff_load;
    logic        ff_pre;
    logic        ff_clr;
    logic [3:0]  gnt;
    logic [3:0]  ack;
    logic [7:0]  rdata;
    logic        busy;
`ifdef DFF_SEQ_CHECK_EN
    logic        err;
`endif

    logic [7:0]  bank;
    logic        ovr_en;
    logic [7:0]  ovr_val;

    int checks;
    int errors;

    typedef struct {
        logic [3:0]  req;
        logic [7:0]  op;
        logic [31:0] wdata;
        logic [3:0]  gnt;
        int          lat;
        logic [7:0]  rdata;
        int          npre;
        int          nclr;
        int          nload;
    } vec_t;

    vec_t vecs [9];

    dff_bank_sequencer #(
        .NREQ      (4),
        .WIDTH     (8),
        .PULSE_CYC (2),
        .RECOV_CYC (1)
    ) dut (
        .clk     (clk),
        .clr_n   (clr_n),
        .req     (req),
        .op      (op),
        .wdata   (wdata),
        .ff_q    (ff_q),
        .ff_d    (ff_d),
        .ff_load (ff_load),
        .ff_pre  (ff_pre),
        .ff_clr  (ff_clr),
        .gnt     (gnt),
        .ack     (ack),
        .rdata   (rdata),
        .busy    (busy)
`ifdef DFF_SEQ_CHECK_EN
        ,
        .err     (err)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Bank model: preset/clear asynchronous, load captured on the clock edge.
    always @(posedge clk or posedge ff_pre or posedge ff_clr) begin
        if (ff_pre)       bank <= 8'hFF;
        else if (ff_clr)  bank <= 8'h00;
        else if (ff_load) bank <= ff_d;
    end

    assign ff_q = ovr_en ? ovr_val : bank;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Bank control exclusivity, checked every cycle out of reset.
    always @(negedge clk) begin
        if (clr_n === 1'b1) begin
            checks++;
            if ((ff_pre && ff_clr) || (ff_load && (ff_pre || ff_clr))) begin
                errors++;
                $display("FAIL excl: pre=%0b clr=%0b load=%0b at %0t", ff_pre, ff_clr, ff_load, $time);
            end
        end
    end

    // One transaction from IDLE: grant next edge, then wait (bounded) for ack.
    task automatic run_txn(input string tag, input vec_t v);
        int  n;
        int  npre;
        int  nclr;
        int  nload;
        bit  done;
        req   = v.req;
        op    = v.op;
        wdata = v.wdata;
        tick();
        chk({tag, " gnt"}, 32'(gnt), 32'(v.gnt));
        chk({tag, " busy"}, 32'(busy), 32'd1);
        n = 0; npre = 0; nclr = 0; nload = 0; done = 1'b0;
        while (!done && n < 12) begin
            if (ack != 4'b0000) begin
                done = 1'b1;
            end else begin
                npre  += int'(ff_pre);
                nclr  += int'(ff_clr);
                nload += int'(ff_load);
                if (ff_load) chk({tag, " ff_d"}, 32'(ff_d), 32'(v.rdata));
                tick();
                n++;
            end
        end
        if (!done) begin
            chk({tag, " ack_timeout"}, 32'd0, 32'd1);
        end else begin
            chk({tag, " latency"}, 32'(n), 32'(v.lat));
            chk({tag, " ack"}, 32'(ack), 32'(v.gnt));
            chk({tag, " rdata"}, 32'(rdata), 32'(v.rdata));
            chk({tag, " gnt_low"}, 32'(gnt), 32'd0);
            chk({tag, " pre_cycles"}, 32'(npre), 32'(v.npre));
            chk({tag, " clr_cycles"}, 32'(nclr), 32'(v.nclr));
            chk({tag, " load_cycles"}, 32'(nload), 32'(v.nload));
        end
        req = 4'b0000;
    endtask

    initial begin
        logic [3:0] e;
        vec_t       v;
        checks  = 0;
        errors  = 0;
        clr_n   = 1'b0;
        req     = 4'b0000;
        op      = 8'h00;
        wdata   = 32'h0;
        ovr_en  = 1'b0;
        ovr_val = 8'h00;

        //           req      op     wdata         gnt      lat rdata  pre clr load
        vecs[0] = '{4'b0100, 8'h00, 32'h00A5_0000, 4'b0100, 2, 8'hA5, 0, 0, 1};
        vecs[1] = '{4'b0001, 8'h01, 32'h0000_0000, 4'b0001, 4, 8'hFF, 2, 0, 0};
        vecs[2] = '{4'b0001, 8'h02, 32'h0000_0000, 4'b0001, 4, 8'h00, 0, 2, 0};
        vecs[3] = '{4'b0010, 8'h0C, 32'h0000_0000, 4'b0010, 1, 8'h00, 0, 0, 0};
        vecs[4] = '{4'b1000, 8'h00, 32'h5A00_0000, 4'b1000, 2, 8'h5A, 0, 0, 1};
        vecs[5] = '{4'b0001, 8'h03, 32'h0000_0000, 4'b0001, 1, 8'h5A, 0, 0, 0};
        vecs[6] = '{4'b0110, 8'h3C, 32'h0000_0000, 4'b0010, 1, 8'h5A, 0, 0, 0};
        vecs[7] = '{4'b1001, 8'h40, 32'h0000_000F, 4'b1000, 4, 8'hFF, 2, 0, 0};
        vecs[8] = '{4'b0011, 8'h02, 32'h0000_0000, 4'b0001, 4, 8'h00, 0, 2, 0};

        // Reset state, held across clock edges.
        repeat (2) @(posedge clk);
        #1;
        chk("rst gnt", 32'(gnt), 32'd0);
        chk("rst ack", 32'(ack), 32'd0);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst ctl", {29'd0, ff_pre, ff_clr, ff_load}, 32'd0);
        chk("rst rdata", 32'(rdata), 32'd0);
        chk("rst ff_d", 32'(ff_d), 32'd0);
        clr_n = 1'b1;
        tick();

        // Round-robin with all four requesters holding READ.
        req = 4'b1111;
        op  = 8'hFF;
        for (int i = 0; i < 5; i++) begin
            e = 4'b0001 << (i % 4);
            tick();
            chk("rr gnt", 32'(gnt), 32'(e));
            tick();
            chk("rr ack", 32'(ack), 32'(e));
            chk("rr gnt_gap", 32'(gnt), 32'd0);
        end
        req = 4'b0000;

        // Table of single transactions.
        for (int i = 0; i < 9; i++) begin
            run_txn($sformatf("vec%0d", i), vecs[i]);
        end

        // Reset asserted between edges while requester 1 has ff_pre high.
        req = 4'b0010;
        op  = 8'h04;
        tick();
        chk("midrst gnt", 32'(gnt), 32'b0010);
        chk("midrst pre_on", 32'(ff_pre), 32'd1);
        #3;
        clr_n = 1'b0;
        #1;
        chk("midrst pre_off", 32'(ff_pre), 32'd0);
        chk("midrst gnt_off", 32'(gnt), 32'd0);
        chk("midrst busy_off", 32'(busy), 32'd0);
        clr_n = 1'b1;
        v = '{4'b0010, 8'h04, 32'h0, 4'b0010, 4, 8'hFF, 2, 0, 0};
        run_txn("after_rst", v);

        // Request dropped and data changed right after grant.
        req   = 4'b1000;
        op    = 8'h00;
        wdata = 32'h3C00_0000;
        tick();
        chk("abort gnt", 32'(gnt), 32'b1000);
        chk("abort load", 32'(ff_load), 32'd1);
        chk("abort ff_d", 32'(ff_d), 32'h3C);
        req   = 4'b0000;
        wdata = 32'h0;
        tick();
        chk("abort load_off", 32'(ff_load), 32'd0);
        tick();
        chk("abort ack", 32'(ack), 32'b1000);
        chk("abort rdata", 32'(rdata), 32'h3C);

`ifdef DFF_SEQ_CHECK_EN
        // Readback corrupted during a SET, then a clean SET.
        ovr_val = 8'hFE;
        ovr_en  = 1'b1;
        v = '{4'b0001, 8'h01, 32'h0, 4'b0001, 4, 8'hFE, 2, 0, 0};
        run_txn("err_bad", v);
        chk("err_bad err", 32'(err), 32'd1);
        ovr_en = 1'b0;
        tick();
        chk("err_clear", 32'(err), 32'd0);
        v = '{4'b0001, 8'h01, 32'h0, 4'b0001, 4, 8'hFF, 2, 0, 0};
        run_txn("err_ok", v);
        chk("err_ok err", 32'(err), 32'd0);
`endif

        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Overall time bound.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
        $fatal(1);
    end

endmodule
